// File: rtl/falafel_req_arbiter.sv
// Arbitrates alloc and free request streams onto a single shared allocator core,
// keeping at most one request outstanding. The mode is set through a config register.
package falafel_req_arbiter_pkg;
    localparam int unsigned DATA_W = 64;

    typedef logic [31:0] alloc_entry_t;

    typedef enum logic [1:0] {
        MODE_RR_0       = 2'b00,
        MODE_ALLOC_PRIO = 2'b01,
        MODE_FREE_PRIO  = 2'b10,
        MODE_RR_3       = 2'b11
    } arb_mode_e;
endpackage

module falafel_req_arbiter
    import falafel_req_arbiter_pkg::*;
#(
    parameter int unsigned         BURST_MAX    = 4,
    parameter logic [DATA_W-1:0]   ARB_CFG_ADDR = 64'h10
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                alloc_req_val_i,
    output logic                alloc_req_rdy_o,
    input  alloc_entry_t        alloc_req_data_i,

    input  logic                free_req_val_i,
    output logic                free_req_rdy_o,
    input  alloc_entry_t        free_req_data_i,

    output logic                core_req_val_o,
    input  logic                core_req_rdy_i,
    output alloc_entry_t        core_req_data_o,
    output logic                core_req_is_alloc_o,
    input  logic                core_done_i,

    input  logic                config_reg_write_i,
    input  logic [DATA_W-1:0]   config_reg_addr_i,
    input  logic [DATA_W-1:0]   config_reg_data_i,

    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_e       state_q, state_d;
    arb_mode_e    mode_q;
    logic [7:0]   burst_q, burst_d;
    logic         last_alloc_q;
    logic         is_alloc_q;
    alloc_entry_t data_q;

    logic         accept;
    logic         grant_alloc;
    logic         alloc_rdy, free_rdy, core_val;
    logic         cfg_hit, mode_change;
    logic         prio_mode, prio_is_alloc, other_val;

    assign cfg_hit     = config_reg_write_i && (config_reg_addr_i == ARB_CFG_ADDR);
    assign mode_change = cfg_hit && (config_reg_data_i[1:0] != mode_q);

    // Selection always uses the registered mode, so a same-cycle config write
    // only affects later arbitrations.
    always_comb begin
        unique case (mode_q)
            MODE_ALLOC_PRIO: grant_alloc = alloc_req_val_i && !(free_req_val_i && burst_q == BURST_LIM);
            MODE_FREE_PRIO:  grant_alloc = alloc_req_val_i && (!free_req_val_i || burst_q == BURST_LIM);
            default:         grant_alloc = alloc_req_val_i && (!free_req_val_i || !last_alloc_q);
        endcase
    end

    assign prio_mode     = (mode_q == MODE_ALLOC_PRIO) || (mode_q == MODE_FREE_PRIO);
    assign prio_is_alloc = (mode_q == MODE_ALLOC_PRIO);
    assign other_val     = prio_is_alloc ? free_req_val_i : alloc_req_val_i;

    always_comb begin
        burst_d = burst_q;
        if (accept && prio_mode) begin
            if (grant_alloc == prio_is_alloc) begin
                if (other_val && burst_q != 8'hFF) begin
                    burst_d = burst_q + 8'd1;
                end
            end else begin
                burst_d = 8'd0;
            end
        end
        if (mode_change) begin
            burst_d = 8'd0;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        alloc_rdy = 1'b0;
        free_rdy  = 1'b0;
        core_val  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (alloc_req_val_i || free_req_val_i) begin
                    accept    = 1'b1;
                    alloc_rdy = grant_alloc;
                    free_rdy  = !grant_alloc;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                core_val = 1'b1;
                if (core_req_rdy_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The latched request is cleared on reset so a dropped request never leaks out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q       <= MODE_RR_0;
            burst_q      <= 8'd0;
            last_alloc_q <= 1'b0;
            is_alloc_q   <= 1'b0;
            data_q       <= '0;
        end else begin
            burst_q <= burst_d;
            if (cfg_hit) begin
                mode_q <= arb_mode_e'(config_reg_data_i[1:0]);
            end
            if (accept) begin
                last_alloc_q <= grant_alloc;
                is_alloc_q   <= grant_alloc;
                data_q       <= grant_alloc ? alloc_req_data_i : free_req_data_i;
            end
        end
    end

    // Reset forces the FSM to IDLE, where ready would otherwise follow valid.
    assign alloc_req_rdy_o     = alloc_rdy && rst_ni;
    assign free_req_rdy_o      = free_rdy && rst_ni;
    assign core_req_val_o      = core_val;
    assign core_req_is_alloc_o = core_val && is_alloc_q;
    assign core_req_data_o     = data_q;
    assign busy_o              = (state_q != IDLE);

endmodule
